// File: rtl/ram_responder_pkg.sv
// Shared encodings for the RAM responder: funct3 size codes, FSM states and
// size/alignment helpers used by the FSM and the lane formatter.
package ram_responder_pkg;

    localparam logic [2:0] MEM_BYTE  = 3'b000;
    localparam logic [2:0] MEM_HALF  = 3'b001;
    localparam logic [2:0] MEM_WORD  = 3'b010;
    localparam logic [2:0] MEM_BYTEU = 3'b100;
    localparam logic [2:0] MEM_HALFU = 3'b101;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_kind_t;

    typedef struct packed {
        size_kind_t kind;
        logic       uns;
    } size_dec_t;

    // Undefined codes (011, 11x) fall through to a signed word access.
    function automatic size_dec_t decode_siz(input logic [2:0] siz);
        size_dec_t d;
        d.kind = SZ_WORD;
        d.uns  = 1'b0;
        case (siz)
            MEM_BYTE:  d.kind = SZ_BYTE;
            MEM_HALF:  d.kind = SZ_HALF;
            MEM_WORD:  d.kind = SZ_WORD;
            MEM_BYTEU: begin d.kind = SZ_BYTE; d.uns = 1'b1; end
            MEM_HALFU: begin d.kind = SZ_HALF; d.uns = 1'b1; end
            default:   d.kind = SZ_WORD;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] align_adr(input logic [31:0] adr, input logic [2:0] siz);
        size_dec_t d;
        d = decode_siz(siz);
        case (d.kind)
            SZ_HALF: return {adr[31:1], 1'b0};
            SZ_WORD: return {adr[31:2], 2'b00};
            default: return adr;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] adr_lo, input logic [2:0] siz);
        size_dec_t d;
        d = decode_siz(siz);
        case (d.kind)
            SZ_HALF: return adr_lo[0];
            SZ_WORD: return |adr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_responder_lane_fmt.sv
// Combinational lane formatter: load extract/extend and store byte-merge
// for a little-endian 32-bit word.
module ram_lane_fmt
    import ram_responder_pkg::*;
(
    input  logic [2:0]  i_siz,
    input  logic [1:0]  i_adr_lo,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_wr_word
);

    size_dec_t   w_dec;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;
    logic [31:0] w_st_pos;

    // NOTE: every output and temporary gets a default at the top of the block
    // so no path through the case leaves one unassigned (which would infer a latch).
    always_comb begin
        w_dec     = decode_siz(i_siz);
        w_byte    = 8'(i_rd_word >> {i_adr_lo, 3'b000});
        w_half    = 16'(i_rd_word >> {i_adr_lo[1], 4'b0000});
        o_ld_data = i_rd_word;
        w_be      = 4'b1111;
        w_st_pos  = i_st_data;
        o_wr_word = i_rd_word;

        case (w_dec.kind)
            SZ_BYTE: begin
                o_ld_data = {{24{w_byte[7] & ~w_dec.uns}}, w_byte};
                w_be      = 4'b0001 << i_adr_lo;
                w_st_pos  = i_st_data << {i_adr_lo, 3'b000};
            end
            SZ_HALF: begin
                o_ld_data = {{16{w_half[15] & ~w_dec.uns}}, w_half};
                w_be      = 4'b0011 << {i_adr_lo[1], 1'b0};
                w_st_pos  = i_st_data << {i_adr_lo[1], 4'b0000};
            end
            default: ;
        endcase

        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) o_wr_word[8*i +: 8] = w_st_pos[8*i +: 8];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Byte-addressed little-endian data RAM with a start/busy/done handshake and
// fixed access latency. Optional misalignment flagging: RAM_ALIGN_CHECK_EN.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_start,
    input  logic        mem_load,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_in,
    input  logic [2:0]  mem_siz,
    output logic [31:0] mem_out,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    ram_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_adr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_siz;
    logic             r_is_store;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic [31:0]      w_adr_in;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_ld_data;
    logic [31:0]      w_wr_word;
    logic             w_mis;
    logic             w_commit;
    logic             w_we;

`ifdef RAM_ALIGN_CHECK_EN
    assign w_adr_in = mem_adr;
    assign w_mis    = is_misaligned(r_adr[1:0], r_siz);
`else
    // Without checking, low address bits are forced to the access alignment.
    assign w_adr_in = align_adr(mem_adr, mem_siz);
    assign w_mis    = 1'b0;
`endif

    assign w_idx     = IDX_W'({2'b00, r_adr[31:2]} % DEPTH_WORDS);
    assign w_rd_word = r_mem[w_idx];
    assign w_commit  = (r_state == RAM_WAIT) && mem_start && (r_cnt == '0);
    assign w_we      = w_commit && r_is_store && !w_mis;

    ram_lane_fmt u_lane_fmt (
        .i_siz     (r_siz),
        .i_adr_lo  (r_adr[1:0]),
        .i_rd_word (w_rd_word),
        .i_st_data (r_wdata),
        .o_ld_data (w_ld_data),
        .o_wr_word (w_wr_word)
    );

    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into a register file. Reset only has to stop an in-flight store, which
    // it does by forcing r_state out of WAIT.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_idx] <= w_wr_word;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RAM_IDLE;
            r_cnt      <= '0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_siz      <= MEM_WORD;
            r_is_store <= 1'b0;
            mem_out    <= '0;
            mem_busy   <= 1'b0;
            mem_done   <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            case (r_state)
                RAM_IDLE: begin
                    if (mem_start) begin
                        r_adr      <= w_adr_in;
                        r_wdata    <= mem_in;
                        r_siz      <= mem_siz;
                        r_is_store <= mem_load;
                        r_cnt      <= CNT_W'(LATENCY - 1);
                        mem_busy   <= 1'b1;
                        r_state    <= RAM_WAIT;
                    end
                end
                RAM_WAIT: begin
                    if (!mem_start) begin
                        mem_busy <= 1'b0;
                        r_state  <= RAM_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        mem_out  <= (r_is_store || w_mis) ? 32'd0 : w_ld_data;
                        mem_err  <= w_mis;
                        mem_busy <= 1'b0;
                        mem_done <= 1'b1;
                        r_state  <= RAM_DONE;
                    end
                end
                RAM_DONE: begin
                    if (!mem_start) begin
                        mem_done <= 1'b0;
                        mem_err  <= 1'b0;
                        r_state  <= RAM_IDLE;
                    end
                end
                default: r_state <= RAM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed-vector bench for ram_responder (DEPTH_WORDS=1024, LATENCY=2);
// expectations follow RAM_ALIGN_CHECK_EN when it is defined.
module tb_ram_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_start = 1'b0;
    logic        mem_load = 1'b0;
    logic [31:0] mem_adr = '0;
    logic [31:0] mem_in = '0;
    logic [2:0]  mem_siz = 3'b010;
    logic [31:0] mem_out;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;

    int n_vec = 0;
    int n_err = 0;

    ram_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_start (mem_start),
        .mem_load  (mem_load),
        .mem_adr   (mem_adr),
        .mem_in    (mem_in),
        .mem_siz   (mem_siz),
        .mem_out   (mem_out),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one request from a negedge; holds start for 'hold' extra cycles in DONE.
    task automatic access(input string tag, input logic st, input logic [31:0] adr,
                          input logic [31:0] data, input logic [2:0] siz, input int hold,
                          output logic [31:0] out, output logic err);
        int cyc;
        mem_start = 1'b1;
        mem_load  = st;
        mem_adr   = adr;
        mem_in    = data;
        mem_siz   = siz;
        cyc = 0;
        do begin
            cycle();
            cyc++;
            // Input changes after acceptance must be ignored.
            mem_adr = ~adr;
            mem_in  = ~data;
            mem_siz = 3'b000;
            mem_load = ~st;
            if (!mem_done) check({tag, "/busy"}, {31'd0, mem_busy}, 32'd1);
        end while (!mem_done && cyc < 20);
        check({tag, "/latency"}, cyc, LATENCY + 1);
        check({tag, "/busy_at_done"}, {31'd0, mem_busy}, 32'd0);
        out = mem_out;
        err = mem_err;
        for (int k = 0; k < hold; k++) begin
            cycle();
            check({tag, "/hold_done"}, {30'd0, mem_busy, mem_done}, 32'd1);
            check({tag, "/hold_out"}, mem_out, out);
        end
        mem_start = 1'b0;
        cycle();
        check({tag, "/done_fall"}, {30'd0, mem_done, mem_err}, 32'd0);
    endtask

    task automatic st_op(input string tag, input logic [31:0] adr, input logic [31:0] data,
                         input logic [2:0] siz, input logic exp_err);
        logic [31:0] out;
        logic        err;
        access(tag, 1'b1, adr, data, siz, 0, out, err);
        check({tag, "/st_out"}, out, 32'd0);
        check({tag, "/st_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic ld_op(input string tag, input logic [31:0] adr, input logic [2:0] siz,
                         input logic [31:0] exp, input logic exp_err);
        logic [31:0] out;
        logic        err;
        access(tag, 1'b0, adr, 32'h0, siz, 0, out, err);
        check({tag, "/ld_out"}, out, exp);
        check({tag, "/ld_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] out;
        logic        err;

        // Reset state
        repeat (2) cycle();
        check("reset/outs", {mem_out[30:0], mem_busy}, 32'd0);
        check("reset/flags", {30'd0, mem_done, mem_err}, 32'd0);
        rst = 1'b1;
        cycle();

        // 1: word store then load
        st_op("sw10", 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        ld_op("lw10", 32'h10, 3'b010, 32'hDEADBEEF, 1'b0);

        // 2: byte store merge and sub-word loads
        st_op("sb11", 32'h11, 32'h0000007F, 3'b000, 1'b0);
        ld_op("lw10b", 32'h10, 3'b010, 32'hDEAD7FEF, 1'b0);
        ld_op("lb13", 32'h13, 3'b000, 32'hFFFFFFDE, 1'b0);
        ld_op("lbu13", 32'h13, 3'b100, 32'h000000DE, 1'b0);
        ld_op("lh12", 32'h12, 3'b001, 32'hFFFFDEAD, 1'b0);
        ld_op("lhu12", 32'h12, 3'b101, 32'h0000DEAD, 1'b0);
        ld_op("lh10", 32'h10, 3'b001, 32'h00007FEF, 1'b0);
        st_op("sh12", 32'h12, 32'hFFFF1234, 3'b001, 1'b0);
        ld_op("lw10c", 32'h10, 3'b010, 32'h12347FEF, 1'b0);
        ld_op("lw_undef011", 32'h10, 3'b011, 32'h12347FEF, 1'b0);
        ld_op("lw_undef111", 32'h10, 3'b111, 32'h12347FEF, 1'b0);

        // 3: reset during WAIT discards the store
        st_op("sw20", 32'h20, 32'hCAFEF00D, 3'b010, 1'b0);
        mem_start = 1'b1; mem_load = 1'b1; mem_adr = 32'h20; mem_in = 32'h1234; mem_siz = 3'b010;
        cycle();
        check("rstwait/busy_before", {31'd0, mem_busy}, 32'd1);
        rst = 1'b0;
        mem_start = 1'b0;
        #1;
        check("rstwait/busy_done", {30'd0, mem_busy, mem_done}, 32'd0);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        ld_op("lw20", 32'h20, 3'b010, 32'hCAFEF00D, 1'b0);

        // 4: abort mid-WAIT, then hold start in DONE
        st_op("sw30", 32'h30, 32'h11111111, 3'b010, 1'b0);
        mem_start = 1'b1; mem_load = 1'b1; mem_adr = 32'h30; mem_in = 32'h22222222; mem_siz = 3'b010;
        cycle();
        mem_start = 1'b0;
        cycle();
        check("abort/busy_done", {30'd0, mem_busy, mem_done}, 32'd0);
        repeat (3) cycle();
        check("abort/idle", {30'd0, mem_busy, mem_done}, 32'd0);
        ld_op("lw30", 32'h30, 3'b010, 32'h11111111, 1'b0);
        access("hold5", 1'b0, 32'h10, 32'h0, 3'b010, 5, out, err);
        check("hold5/out", out, 32'h12347FEF);

        // 5: address wrap and misalignment
        ld_op("lw_alias", DEPTH_WORDS * 4 + 32'h10, 3'b010, 32'h12347FEF, 1'b0);
        st_op("sw40", 32'h40, 32'h00000000, 3'b010, 1'b0);
`ifdef RAM_ALIGN_CHECK_EN
        ld_op("lh11_mis", 32'h11, 3'b001, 32'h00000000, 1'b1);
        st_op("sw42_mis", 32'h42, 32'hA5A5A5A5, 3'b010, 1'b1);
        ld_op("lw40", 32'h40, 3'b010, 32'h00000000, 1'b0);
`else
        ld_op("lh11_mask", 32'h11, 3'b001, 32'h00007FEF, 1'b0);
        st_op("sw42_mask", 32'h42, 32'hA5A5A5A5, 3'b010, 1'b0);
        ld_op("lw40", 32'h40, 3'b010, 32'hA5A5A5A5, 1'b0);
`endif

        // 6: back-to-back requests with a single low cycle between them
        st_op("b2b_sw", 32'h50, 32'h0BADF00D, 3'b010, 1'b0);
        ld_op("b2b_lw", 32'h50, 3'b010, 32'h0BADF00D, 1'b0);
        ld_op("b2b_lbu", 32'h53, 3'b100, 32'h0000000B, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
